// File: rtl/shared_enc_ctrl.sv
// Iterative sequencer for a two-share threshold-implementation round function.
// Shares travel in parallel lanes and are never combined inside this block.
module shared_enc_ctrl #(
  parameter int ROUNDS = 16,
  parameter int RF_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] pt0,
  input  logic [127:0] pt1,
  input  logic [127:0] rk0,
  input  logic [127:0] rk1,
  output logic         key_load,
  output logic         key_next,
  output logic [4:0]   round_idx,
  output logic [127:0] rf_in0,
  output logic [127:0] rf_in1,
  input  logic [127:0] rf_out0,
  input  logic [127:0] rf_out1,
  output logic         busy,
  output logic         done,
  output logic [127:0] ct0,
  output logic [127:0] ct1
);

  localparam int            WW       = (RF_LAT > 0) ? $clog2(RF_LAT + 1) : 1;
  localparam logic [WW-1:0] LAT_V    = WW'(RF_LAT);
  localparam logic [4:0]    LAST_RND = 5'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wcnt;
  logic [127:0]  s0, s1;
  logic          accept, capture;

  assign rf_in0 = s0;
  assign rf_in1 = s1;

  // Reset wins over a same-cycle start or capture, so the key schedule never
  // sees a pulse from a cycle that is being discarded.
  assign key_load = accept  & ~rst;
  assign key_next = capture & ~rst;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (wcnt == LAT_V) begin
          capture = 1'b1;
          if (round_idx == LAST_RND) state_nxt = FINAL;
        end
      end
      FINAL: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    // NOTE: the state shares and ciphertext are plain registers, not a memory,
    // so they are reset; a reset mid-encryption must not leave share data behind.
    if (rst) begin
      s0        <= '0;
      s1        <= '0;
      ct0       <= '0;
      ct1       <= '0;
      wcnt      <= '0;
      round_idx <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == FINAL);
      if (accept) begin
        s0        <= pt0;
        s1        <= pt1;
        wcnt      <= '0;
        round_idx <= '0;
      end else if (state == RUN) begin
        if (capture) begin
          s0        <= rf_out0;
          s1        <= rf_out1;
          wcnt      <= '0;
          round_idx <= round_idx + 5'd1;
        end else begin
          wcnt <= wcnt + WW'(1);
        end
      end
      // Final whitening with key ROUNDS, lane by lane.
      if (state == FINAL) begin
        ct0 <= s0 ^ rk0;
        ct1 <= s1 ^ rk1;
      end
    end
  end

endmodule

// File: doc/shared_enc_ctrl.md
Name: shared_enc_ctrl

Overview:
- Iterative sequencer for the two-share threshold-implementation encryption round function.
- Latches the plaintext shares, presents the state shares to the external round-function instance, and waits out its S-box register latency.
- Writes the round output back each round, advances the external shared key schedule, and applies the final key whitening.
- Sits between the top-level cipher wrapper and the round datapath. The two shares are never combined anywhere inside this block.

Parameters:
- ROUNDS, 16, number of round-function applications (1..31).
- RF_LAT, 1, clock cycles from rf_in* change to valid rf_out* (0 = purely combinational round function).

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new encryption; sampled only in IDLE
- pt0  in  128  plaintext share 0, sampled with accepted start
- pt1  in  128  plaintext share 1
- rk0  in  128  current round-key share 0 from key schedule
- rk1  in  128  current round-key share 1
- key_load  out  1  one-cycle pulse: key schedule loads master-key shares
- key_next  out  1  one-cycle pulse: key schedule advances one round
- round_idx  out  5  index of the round currently being computed
- rf_in0  out  128  state share 0 to round function
- rf_in1  out  128  state share 1 to round function
- rf_out0  in  128  round-function output share 0
- rf_out1  in  128  round-function output share 1
- busy  out  1  high while an encryption is in progress
- done  out  1  one-cycle pulse, ct* valid
- ct0  out  128  ciphertext share 0, held until next accepted start
- ct1  out  128  ciphertext share 1

Behaviour:
- Reset values (synchronous rst=1):
  - FSM=IDLE; state regs s0=s1=0; ct0=ct1=0.
  - busy=0, done=0, key_load=0, key_next=0, round_idx=0, wait counter=0.
  - rst overrides every other input in the same cycle.
- Combinational datapath outputs: rf_in0=s0, rf_in1=s1 at all times.
- States: IDLE, RUN, FINAL.
- IDLE:
  - If start=1 (cycle 0): s0<=pt0, s1<=pt1, round_idx<=0, wcnt<=0, key_load=1 this cycle, next RUN.
  - Otherwise hold.
- RUN:
  - busy=1.
  - While wcnt<RF_LAT: wcnt++, hold s*.
  - When wcnt==RF_LAT (capture cycle): s0<=rf_out0, s1<=rf_out1, key_next=1, wcnt<=0, round_idx++.
  - If round_idx==ROUNDS-1 at capture, next FINAL.
  - Each round lasts RF_LAT+1 cycles.
  - rk* must be valid for round_idx throughout RUN; the key schedule presents key i+1 by the cycle after key_next.
- FINAL:
  - busy=1, one cycle.
  - ct0<=s0^rk0, ct1<=s1^rk1 (share-wise XOR with key ROUNDS); done<=1 (registered); next IDLE.
- done:
  - High exactly one cycle, the cycle after FINAL (FSM already IDLE, busy=0).
  - A start in that cycle is accepted.
- Latency: start accepted at cycle 0 → done high at cycle ROUNDS*(RF_LAT+1)+2.
- start while busy=1 is ignored. No queuing, no side effects.
- pt* changes while busy are ignored.
- ct* change only in FINAL. They are never zeroed except by rst.
- round_idx in FINAL equals ROUNDS. It returns to 0 only on the next accepted start or rst.
- key_load and key_next are never asserted in the same cycle.
- Exactly ROUNDS key_next pulses per encryption.
- Reset mid-encryption: next cycle IDLE with all reset values, no done pulse, and ct* are cleared.
- Share-wise operation only: no expression combines a share-0 signal with a share-1 signal.

Test Plan:
- rst held 3 cycles with random inputs → all outputs 0 and busy=0; start asserted during rst → ignored.
- ROUNDS=16, RF_LAT=1, golden unmasked model driving rf_out*/rk*, random masks:
  - start at cycle 0 → key_load at cycle 0 and key_next at cycles 2,4,…,32.
  - FINAL at 33, done at cycle 34 only.
  - ct0^ct1 equals the unmasked uBlock-128/128 ciphertext.
- Same stimulus with RF_LAT=0 → key_next every cycle 1..16, done at cycle 18, identical ct0^ct1.
- start pulsed at cycles 5 and 20 during busy, with pt* changed → ignored; ct0^ct1 matches the first plaintext; single done at 34.
- rst asserted at cycle 10 of an encryption → IDLE at cycle 11, no done, ct*=0; new start at cycle 12 → done at cycle 46 with correct ct.
- start asserted in the done cycle (34) with new plaintext → accepted; second done at cycle 68; first ct held through cycles 34..66; both results correct.
